packet_receiver: RTL and testbench
==================================

PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter UWIDTH, default 8, byte width of packet stream and FIFO write data.
REQ-002 SHALL have parameter PTR_IN_SZ, default 4, width of intra-slot FIFO write address.
REQ-003 SHALL have parameter MAX_SIZE, default 7, largest legal payload byte count; 4+MAX_SIZE <= 2**PTR_IN_SZ and <= FIFO slot WIDTH (11).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port packet_valid  input  1  high while a packet byte is present on packet_in.
REQ-007 SHALL have port packet_in  input  UWIDTH  incoming packet byte.
REQ-008 SHALL have port wfull  input  1  FIFO full flag.
REQ-009 SHALL have port winc  output  1  one-cycle commit of the current FIFO slot.
REQ-010 SHALL have port waddr_in  output  PTR_IN_SZ  byte position within the FIFO slot.
REQ-011 SHALL have port wdata  output  UWIDTH  byte written at waddr_in.
REQ-012 SHALL have port pkt_ok  output  1  one-cycle pulse: packet committed.
REQ-013 SHALL have port pkt_err  output  1  one-cycle pulse: packet dropped.
REQ-014 SHALL have port err_code  output  2  drop cause, valid with pkt_err: 0 fifo full, 1 bad size, 2 truncated, 3 crc mismatch.
REQ-015 SHALL have port rx_count  output  8  saturating count of committed packets.
REQ-016 SHALL have port drop_count  output  8  saturating count of dropped packets.

Function
REQ-017 SHALL accept packet format: source_id, dest_id, size, size data bytes, crc; one byte per clk while packet_valid=1.
REQ-018 SHALL define crc as XOR of all preceding bytes (source_id through last data byte).
REQ-019 SHALL implement states IDLE, SRC, DST, SIZE, DATA, CRC, DROP.
REQ-020 IDLE: packet_valid=1 with wfull=0 -> byte taken as source_id, go DST; with wfull=1 -> pkt_err, err_code=0, go DROP.
REQ-021 DST -> SIZE -> DATA on consecutive valid bytes; SIZE byte of 0 or >MAX_SIZE -> pkt_err, err_code=1, go DROP.
REQ-022 DATA: counts size bytes, then CRC; CRC byte ends packet, return to IDLE.
REQ-023 Each accepted byte at index k SHALL appear as wdata=byte, waddr_in=k on the cycle after its sampling edge (1-cycle latency); index 0 = source_id.
REQ-024 CRC byte matching running XOR: winc=1 and pkt_ok=1 on the same cycle its wdata/waddr_in appear; mismatch: winc=0, pkt_err=1, err_code=3.
REQ-025 winc SHALL never assert for a dropped packet; its slot is overwritten by the next packet.
REQ-026 packet_valid=0 in DST, SIZE, DATA or CRC -> pkt_err, err_code=2, go IDLE (not DROP).
REQ-027 DROP: ignore bytes; exit to IDLE on first cycle with packet_valid=0.
REQ-028 Back-to-back: valid byte on cycle after CRC byte SHALL be accepted as a new source_id.
REQ-029 wfull sampled only at source_id; not rechecked mid-packet.
REQ-030 rx_count increments with pkt_ok, drop_count with pkt_err; both hold at 255.
REQ-031 pkt_ok and pkt_err SHALL never assert together.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, winc=0, waddr_in=0, wdata=0, pkt_ok=0, pkt_err=0, err_code=0, rx_count=0, drop_count=0.
REQ-033 rst mid-packet SHALL abandon the packet with no winc and no pkt_err; packet_valid=1 on the first cycle after rst releases starts a new packet.

Verification
REQ-034 Bytes 10,160,3,0,1,2,0xAA, wfull=0 -> waddr_in 0..6 with matching wdata, winc=1 and pkt_ok=1 with waddr_in=6, rx_count=1.
REQ-035 Bytes 100,10,4,0,1,2,3,106 immediately after REQ-034 packet -> second commit with waddr_in=7, rx_count=2, no idle cycle required.
REQ-036 Same as REQ-034 but crc=15 -> winc stays 0, pkt_err=1, err_code=3, drop_count=1.
REQ-037 wfull=1 at source_id byte of 7-byte packet -> pkt_err, err_code=0, no wdata-driven winc, IDLE after packet_valid falls.
REQ-038 size byte 8 (MAX_SIZE=7) -> err_code=1; packet_valid dropped after 2nd data byte of legal packet -> err_code=2; both with no winc.
REQ-039 rst pulse at data byte 2 of a packet -> all outputs zero, no pulses; following legal packet commits with rx_count=1.

Source files
------------

// File: rtl/packet_receiver.sv
// packet_receiver: parses a byte-serial packet stream and writes each accepted
// byte into the current FIFO slot.
// Packet format: source_id, dest_id, size, size data bytes, crc. The crc is the
// XOR of every byte before it. A packet with a good crc is committed with winc.
// Any other packet is dropped with pkt_err and a cause code, and the next
// packet overwrites its slot.
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   packet_valid      a byte is present on packet_in this cycle
//   packet_in         incoming packet byte
//   wfull             FIFO full, checked only on the source_id byte
//   winc              one-cycle commit of the current FIFO slot
//   waddr_in, wdata   byte position within the slot and the byte written there
//   pkt_ok, pkt_err   one-cycle packet committed / packet dropped pulses
//   err_code          drop cause, valid with pkt_err:
//                     0 fifo full, 1 bad size, 2 truncated, 3 crc mismatch
//   rx_count          saturating count of committed packets
//   drop_count        saturating count of dropped packets
module packet_receiver #(
   parameter int unsigned UWIDTH    = 8,
   parameter int unsigned PTR_IN_SZ = 4,
   parameter int unsigned MAX_SIZE  = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 packet_valid,
   input  logic [UWIDTH-1:0]    packet_in,
   input  logic                 wfull,
   output logic                 winc,
   output logic [PTR_IN_SZ-1:0] waddr_in,
   output logic [UWIDTH-1:0]    wdata,
   output logic                 pkt_ok,
   output logic                 pkt_err,
   output logic [1:0]           err_code,
   output logic [7:0]           rx_count,
   output logic [7:0]           drop_count
);

   localparam int unsigned CNT_W = 8;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SRC  = 3'd1;
   localparam logic [2:0] S_DST  = 3'd2;
   localparam logic [2:0] S_SIZE = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_CRC  = 3'd5;
   localparam logic [2:0] S_DROP = 3'd6;

   localparam logic [1:0] ERR_FULL  = 2'd0;
   localparam logic [1:0] ERR_SIZE  = 2'd1;
   localparam logic [1:0] ERR_TRUNC = 2'd2;
   localparam logic [1:0] ERR_CRC   = 2'd3;

   logic [2:0]           state,      state_n;
   logic [UWIDTH-1:0]    crc_acc,    crc_acc_n;
   logic [UWIDTH-1:0]    remain,     remain_n;
   logic                 winc_n;
   logic [PTR_IN_SZ-1:0] waddr_n;
   logic [UWIDTH-1:0]    wdata_n;
   logic                 pkt_ok_n;
   logic                 pkt_err_n;
   logic [1:0]           err_code_n;
   logic [CNT_W-1:0]     rx_count_n;
   logic [CNT_W-1:0]     drop_count_n;

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state;
      crc_acc_n    = crc_acc;
      remain_n     = remain;
      winc_n       = 1'b0;
      waddr_n      = waddr_in;
      wdata_n      = wdata;
      pkt_ok_n     = 1'b0;
      pkt_err_n    = 1'b0;
      err_code_n   = err_code;
      rx_count_n   = rx_count;
      drop_count_n = drop_count;

      case (state)
         // S_SRC is never entered: the source_id byte is taken straight from idle
         // so that a packet can follow a crc byte with no gap.
         S_IDLE, S_SRC: begin
            if (packet_valid) begin
               if (wfull) begin
                  pkt_err_n  = 1'b1;
                  err_code_n = ERR_FULL;
                  state_n    = S_DROP;
               end else begin
                  wdata_n   = packet_in;
                  waddr_n   = PTR_IN_SZ'(0);
                  crc_acc_n = packet_in;
                  state_n   = S_DST;
               end
            end
         end

         S_DST: begin
            if (!packet_valid) begin
               pkt_err_n  = 1'b1;
               err_code_n = ERR_TRUNC;
               state_n    = S_IDLE;
            end else begin
               wdata_n   = packet_in;
               waddr_n   = waddr_in + PTR_IN_SZ'(1);
               crc_acc_n = crc_acc ^ packet_in;
               state_n   = S_SIZE;
            end
         end

         S_SIZE: begin
            if (!packet_valid) begin
               pkt_err_n  = 1'b1;
               err_code_n = ERR_TRUNC;
               state_n    = S_IDLE;
            end else begin
               wdata_n   = packet_in;
               waddr_n   = waddr_in + PTR_IN_SZ'(1);
               crc_acc_n = crc_acc ^ packet_in;
               if ((packet_in == UWIDTH'(0)) || (packet_in > UWIDTH'(MAX_SIZE))) begin
                  pkt_err_n  = 1'b1;
                  err_code_n = ERR_SIZE;
                  state_n    = S_DROP;
               end else begin
                  remain_n = packet_in;
                  state_n  = S_DATA;
               end
            end
         end

         // remain counts data bytes still expected, including this one.
         S_DATA: begin
            if (!packet_valid) begin
               pkt_err_n  = 1'b1;
               err_code_n = ERR_TRUNC;
               state_n    = S_IDLE;
            end else begin
               wdata_n   = packet_in;
               waddr_n   = waddr_in + PTR_IN_SZ'(1);
               crc_acc_n = crc_acc ^ packet_in;
               remain_n  = remain - UWIDTH'(1);
               if (remain == UWIDTH'(1)) begin
                  state_n = S_CRC;
               end
            end
         end

         // The crc byte is written like any other; only a match commits the slot.
         S_CRC: begin
            if (!packet_valid) begin
               pkt_err_n  = 1'b1;
               err_code_n = ERR_TRUNC;
            end else begin
               wdata_n = packet_in;
               waddr_n = waddr_in + PTR_IN_SZ'(1);
               if (packet_in == crc_acc) begin
                  winc_n   = 1'b1;
                  pkt_ok_n = 1'b1;
               end else begin
                  pkt_err_n  = 1'b1;
                  err_code_n = ERR_CRC;
               end
            end
            state_n = S_IDLE;
         end

         // Discard the rest of a rejected packet until the stream goes idle.
         S_DROP: begin
            if (!packet_valid) begin
               state_n = S_IDLE;
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      if (pkt_ok_n && (rx_count != {CNT_W{1'b1}})) begin
         rx_count_n = rx_count + CNT_W'(1);
      end
      if (pkt_err_n && (drop_count != {CNT_W{1'b1}})) begin
         drop_count_n = drop_count + CNT_W'(1);
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         crc_acc    <= '0;
         remain     <= '0;
         winc       <= 1'b0;
         waddr_in   <= '0;
         wdata      <= '0;
         pkt_ok     <= 1'b0;
         pkt_err    <= 1'b0;
         err_code   <= ERR_FULL;
         rx_count   <= '0;
         drop_count <= '0;
      end else begin
         state      <= state_n;
         crc_acc    <= crc_acc_n;
         remain     <= remain_n;
         winc       <= winc_n;
         waddr_in   <= waddr_n;
         wdata      <= wdata_n;
         pkt_ok     <= pkt_ok_n;
         pkt_err    <= pkt_err_n;
         err_code   <= err_code_n;
         rx_count   <= rx_count_n;
         drop_count <= drop_count_n;
      end
   end

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: scoreboard bench for packet_receiver.
// The driver classifies every packet from the packet rules before sending it
// and queues the expected outcome, its cycle and the expected counters. The
// monitor mirrors the FIFO slot from waddr_in/wdata and checks each pulse
// against the queue, including the committed slot contents.
module tb_packet_receiver;

   localparam int unsigned UW = 8;
   localparam int unsigned PW = 4;
   localparam int unsigned MS = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          packet_valid;
   logic [UW-1:0] packet_in;
   logic          wfull;
   logic          winc;
   logic [PW-1:0] waddr_in;
   logic [UW-1:0] wdata;
   logic          pkt_ok;
   logic          pkt_err;
   logic [1:0]    err_code;
   logic [7:0]    rx_count;
   logic [7:0]    drop_count;

   packet_receiver #(.UWIDTH(UW), .PTR_IN_SZ(PW), .MAX_SIZE(MS)) dut (
      .clk(clk), .rst(rst), .packet_valid(packet_valid), .packet_in(packet_in),
      .wfull(wfull), .winc(winc), .waddr_in(waddr_in), .wdata(wdata),
      .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code),
      .rx_count(rx_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit   ok;
      int   code;
      int   cyc;
      int   rx;
      int   drop;
      int   len;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] slot_q[$];
   logic [7:0] pb [0:15];
   logic [7:0] shadow [0:15];
   int         checks = 0;
   int         errors = 0;
   int         mrx = 0;
   int         mdrop = 0;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Classify the packet in pb[0:len-1] of which n bytes are sent, queue the
   // expected outcome, then drive it followed by gap idle cycles.
   task automatic send(input int len, input int n, input bit wf0, input int gap);
      int         start;
      int         idx;
      int         code;
      bit         ok;
      int         size;
      logic [7:0] x;
      exp_t       e;
      start = cyc;
      ok    = 1'b0;
      code  = 0;
      if (wf0) begin
         idx = 0;  code = 0;
      end else if (n < 3) begin
         idx = n;  code = 2;
      end else begin
         size = int'(pb[2]);
         if (size == 0 || size > int'(MS)) begin
            idx = 2;  code = 1;
         end else if (n < size + 4) begin
            idx = n;  code = 2;
         end else begin
            x = 8'd0;
            for (int i = 0; i < size + 3; i++) x = x ^ pb[i];
            idx = size + 3;
            if (x == pb[size + 3]) ok = 1'b1;
            else code = 3;
         end
      end
      if (ok) begin
         if (mrx < 255) mrx++;
         for (int i = 0; i <= idx; i++) slot_q.push_back(pb[i]);
      end else begin
         if (mdrop < 255) mdrop++;
      end
      e.ok = ok;  e.code = code;  e.cyc = start + idx + 1;
      e.rx = mrx; e.drop = mdrop; e.len = idx + 1;
      exp_q.push_back(e);
      len = len;
      for (int i = 0; i < n; i++) begin
         packet_valid = 1'b1;
         packet_in    = pb[i];
         wfull        = (i == 0) ? wf0 : 1'($urandom);
         @(negedge clk);
      end
      for (int g = 0; g < gap; g++) begin
         packet_valid = 1'b0;
         packet_in    = 8'($urandom);
         wfull        = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_winc"},  int'(winc), 0);
      check({tag, "_waddr"}, int'(waddr_in), 0);
      check({tag, "_wdata"}, int'(wdata), 0);
      check({tag, "_ok"},    int'(pkt_ok), 0);
      check({tag, "_err"},   int'(pkt_err), 0);
      check({tag, "_code"},  int'(err_code), 0);
      check({tag, "_rx"},    int'(rx_count), 0);
      check({tag, "_drop"},  int'(drop_count), 0);
   endtask

   // Monitor: mirror the slot, then match pulses against the scoreboard.
   exp_t m;
   always @(negedge clk) begin
      shadow[waddr_in] = wdata;
      check("winc_eq_ok", int'(winc), int'(pkt_ok));
      check("ok_err_excl", int'(pkt_ok && pkt_err), 0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         m = exp_q.pop_front();
         check("missed_pulse_cycle", cyc, m.cyc);
         if (m.ok) for (int i = 0; i < m.len; i++) void'(slot_q.pop_front());
      end
      if (pkt_ok || pkt_err) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", int'({pkt_ok, pkt_err}), 0);
         end else begin
            m = exp_q.pop_front();
            check("pulse_cycle", cyc, m.cyc);
            check("pkt_ok", int'(pkt_ok), int'(m.ok));
            if (!m.ok) check("err_code", int'(err_code), m.code);
            check("rx_count", int'(rx_count), m.rx);
            check("drop_count", int'(drop_count), m.drop);
            if (m.ok) begin
               check("commit_waddr", int'(waddr_in), m.len - 1);
               for (int i = 0; i < m.len; i++) begin
                  if (slot_q.size() > 0) check("slot_byte", int'(shadow[i]), int'(slot_q.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int size, len, n, gap, r;
      bit wf0, legal;
      rst = 1'b1;  packet_valid = 1'b0;  packet_in = 8'd0;  wfull = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Good packet, then a second one back-to-back.
      pb[0] = 8'd10;  pb[1] = 8'd160; pb[2] = 8'd3;   pb[3] = 8'd0;
      pb[4] = 8'd1;   pb[5] = 8'd2;   pb[6] = 8'hAA;
      send(7, 7, 1'b0, 0);
      pb[0] = 8'd100; pb[1] = 8'd10;  pb[2] = 8'd4;   pb[3] = 8'd0;
      pb[4] = 8'd1;   pb[5] = 8'd2;   pb[6] = 8'd3;   pb[7] = 8'd106;
      send(8, 8, 1'b0, 1);
      // Bad crc.
      pb[0] = 8'd10;  pb[1] = 8'd160; pb[2] = 8'd3;   pb[3] = 8'd0;
      pb[4] = 8'd1;   pb[5] = 8'd2;   pb[6] = 8'd15;
      send(7, 7, 1'b0, 1);
      // FIFO full at source_id.
      pb[6] = 8'hAA;
      send(7, 7, 1'b1, 1);
      // Oversized size byte.
      pb[0] = 8'd1;  pb[1] = 8'd2;  pb[2] = 8'd8;
      for (int i = 3; i < 12; i++) pb[i] = 8'(i);
      send(12, 12, 1'b0, 1);
      // Truncated after the second data byte.
      pb[2] = 8'd3;
      send(7, 5, 1'b0, 1);

      // Reset in the middle of a packet, then a packet right after release.
      pb[0] = 8'd20; pb[1] = 8'd30; pb[2] = 8'd3; pb[3] = 8'd7; pb[4] = 8'd8;
      for (int i = 0; i < 5; i++) begin
         packet_valid = 1'b1;  packet_in = pb[i];  wfull = 1'b0;
         @(negedge clk);
      end
      packet_in = 8'd9;  rst = 1'b1;
      @(negedge clk);
      check_zero("midrst");
      mrx = 0;  mdrop = 0;
      rst = 1'b0;
      pb[0] = 8'd10;  pb[1] = 8'd160; pb[2] = 8'd3;   pb[3] = 8'd0;
      pb[4] = 8'd1;   pb[5] = 8'd2;   pb[6] = 8'hAA;
      send(7, 7, 1'b0, 1);

      // Randomised traffic.
      for (int p = 0; p < 300; p++) begin
         r = int'($urandom_range(0, 9));
         if (r < 8) begin
            size = int'($urandom_range(1, MS));
            len  = size + 4;
         end else begin
            size = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MS + 1, 255));
            len  = 3 + int'($urandom_range(0, 4));
         end
         pb[0] = 8'($urandom);  pb[1] = 8'($urandom);  pb[2] = 8'(size);
         for (int i = 3; i < len; i++) pb[i] = 8'($urandom);
         if (r < 8) begin
            pb[len - 1] = 8'd0;
            for (int i = 0; i < len - 1; i++) pb[len - 1] = pb[len - 1] ^ pb[i];
            if ($urandom_range(0, 4) == 0) pb[len - 1] = pb[len - 1] ^ 8'(1 + $urandom_range(0, 254));
         end
         n     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, len - 1)) : len;
         wf0   = ($urandom_range(0, 7) == 0);
         legal = (r < 8) && (n == len) && !wf0;
         gap   = legal ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
         send(len, n, wf0, gap);
      end

      // Saturate both counters.
      for (int p = 0; p < 260; p++) send(1, 1, 1'b1, 1);
      pb[0] = 8'd5;  pb[1] = 8'd6;  pb[2] = 8'd1;  pb[3] = 8'd7;
      pb[4] = 8'd5 ^ 8'd6 ^ 8'd1 ^ 8'd7;
      for (int p = 0; p < 260; p++) send(5, 5, 1'b0, 0);
      packet_valid = 1'b0;

      repeat (5) @(negedge clk);
      check("pending_events", exp_q.size(), 0);
      check("final_rx_sat", int'(rx_count), 255);
      check("final_drop_sat", int'(drop_count), 255);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
